// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
// Holds the default data-memory geometry, the word size in bytes and the
// control bundle carried by the MEM/WB pipeline register.
package pipeline_pkg;

  localparam int DEFAULT_DATA_DEPTH = 256;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int WORD_BYTES         = 4;

  // Control bits that travel with a MEM/WB entry.
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_fault;
  } memwb_ctrl_t;

endpackage

// File: rtl/data_memory.sv
// Single-port word-addressed data memory.
// Write is synchronous; read is synchronous and write-first, so a combined
// read/write returns the data being written. The read register doubles as
// the loaded-word slot of the MEM/WB register.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high; clears read_data, blocks writes,
//              leaves the array contents alone
//   write_en   write write_data into mem[index] at the edge
//   read_en    load mem[index] into read_data at the edge, else load 0
//   index      word index
//   write_data store data
//   read_data  registered read result
module data_memory #(
  parameter int DATA_DEPTH = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data
);

  logic [31:0] mem [DATA_DEPTH];

  always_ff @(posedge clock) begin
    // Contents are never cleared by reset; only the write is suppressed.
    if (!reset && write_en) begin
      mem[index] <= write_data;
    end

    if (reset) begin
      read_data <= '0;
    end else if (read_en) begin
      read_data <= write_en ? write_data : mem[index];
    end else begin
      read_data <= '0;
    end
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage of the pipeline plus the MEM/WB pipeline register.
// Loads/stores go to the data_memory instance using the word index taken
// from the byte address; misaligned accesses neither write nor read and are
// flagged through mem_fault_out. Branch resolution to fetch is combinational.
// Ports:
//   clock, reset                       stage clock, synchronous active-high reset
//   result_in                          ALU result / byte address
//   registro_2_in                      store data
//   reg_dest_in                        destination register
//   jump_dest_addr_in, zero_signal_in  branch target and ALU zero flag
//   MemToReg_in .. Branch_in           EX/MEM control
//   read_data_out .. mem_fault_out     MEM/WB register outputs
//   PCSrc_out, branch_target_out       branch decision and target to fetch
module memory_access
  import pipeline_pkg::*;
#(
  parameter int DATA_DEPTH = DEFAULT_DATA_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] result_in,
  input  logic [31:0] registro_2_in,
  input  logic [4:0]  reg_dest_in,
  input  logic [10:0] jump_dest_addr_in,
  input  logic        zero_signal_in,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  output logic [31:0] read_data_out,
  output logic [31:0] result_out,
  output logic [4:0]  reg_dest_out,
  output logic        MemToReg_out,
  output logic        RegWrite_out,
  output logic        mem_fault_out,
  output logic        PCSrc_out,
  output logic [10:0] branch_target_out
);

  logic                  aligned;
  logic [ADDR_WIDTH-1:0] word_index;
  memwb_ctrl_t           ctrl_q;

  // Byte address bits above the memory size are dropped, so addresses wrap.
  assign aligned    = (result_in[1:0] == 2'b00);
  assign word_index = result_in[ADDR_WIDTH+1:2];

  data_memory #(
    .DATA_DEPTH (DATA_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_data_memory (
    .clock      (clock),
    .reset      (reset),
    .write_en   (MemWrite_in & aligned),
    .read_en    (MemRead_in & aligned),
    .index      (word_index),
    .write_data (registro_2_in),
    .read_data  (read_data_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      result_out   <= '0;
      reg_dest_out <= '0;
      ctrl_q       <= '0;
    end else begin
      result_out           <= result_in;
      reg_dest_out         <= reg_dest_in;
      ctrl_q.mem_to_reg    <= MemToReg_in;
      // A misaligned load produced no data, so it must not write back.
      ctrl_q.reg_write     <= RegWrite_in & ~(MemRead_in & ~aligned);
      ctrl_q.mem_fault     <= (MemRead_in | MemWrite_in) & ~aligned;
    end
  end

  assign MemToReg_out  = ctrl_q.mem_to_reg;
  assign RegWrite_out  = ctrl_q.reg_write;
  assign mem_fault_out = ctrl_q.mem_fault;

  assign PCSrc_out         = ~reset & Branch_in & zero_signal_in;
  assign branch_target_out = jump_dest_addr_in;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: random and directed stimulus, expected MEM/WB
// entries queued by the driver from a reference model, popped and compared
// by an independent monitor after every rising edge.
module tb_memory_access;

  localparam int W = 72;  // {read_data, result, reg_dest, mem_to_reg, reg_write, mem_fault}

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] result_in;
  logic [31:0] registro_2_in;
  logic [4:0]  reg_dest_in;
  logic [10:0] jump_dest_addr_in;
  logic        zero_signal_in;
  logic        MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in;
  logic [31:0] read_data_out;
  logic [31:0] result_out;
  logic [4:0]  reg_dest_out;
  logic        MemToReg_out, RegWrite_out, mem_fault_out, PCSrc_out;
  logic [10:0] branch_target_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  ref_mem [256];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  memory_access dut (
    .clock             (clock),
    .reset             (reset),
    .result_in         (result_in),
    .registro_2_in     (registro_2_in),
    .reg_dest_in       (reg_dest_in),
    .jump_dest_addr_in (jump_dest_addr_in),
    .zero_signal_in    (zero_signal_in),
    .MemToReg_in       (MemToReg_in),
    .RegWrite_in       (RegWrite_in),
    .MemRead_in        (MemRead_in),
    .MemWrite_in       (MemWrite_in),
    .Branch_in         (Branch_in),
    .read_data_out     (read_data_out),
    .result_out        (result_out),
    .reg_dest_out      (reg_dest_out),
    .MemToReg_out      (MemToReg_out),
    .RegWrite_out      (RegWrite_out),
    .mem_fault_out     (mem_fault_out),
    .PCSrc_out         (PCSrc_out),
    .branch_target_out (branch_target_out)
  );

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns the MEM/WB entry the edge should produce and updates the model memory.
  function automatic logic [W-1:0] model_edge(
    input logic rst, input logic [31:0] addr, input logic [31:0] data,
    input logic [4:0] dest, input logic mtr, input logic rw,
    input logic mr, input logic mw);
    int   idx;
    logic ok;
    logic [31:0] rd;
    if (rst) return '0;
    idx = int'(addr % 1024) / 4;
    ok  = (addr % 4) == 0;
    if (mw && ok) ref_mem[idx] = data;
    rd = (mr && ok) ? ref_mem[idx] : 32'h0;
    return {rd, addr, dest, mtr, rw && !(mr && !ok), (mr || mw) && !ok};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(
    input logic rst, input logic [31:0] addr, input logic [31:0] data,
    input logic [4:0] dest, input logic mtr, input logic rw,
    input logic mr, input logic mw,
    input logic br, input logic z, input logic [10:0] jmp);
    @(negedge clock);
    reset = rst; result_in = addr; registro_2_in = data; reg_dest_in = dest;
    MemToReg_in = mtr; RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw;
    Branch_in = br; zero_signal_in = z; jump_dest_addr_in = jmp;
    exp_q.push_back(model_edge(rst, addr, data, dest, mtr, rw, mr, mw));
    #1;
    check_val("pcsrc", {31'h0, PCSrc_out}, {31'h0, !rst && br && z});
    check_val("branch_target", {21'h0, branch_target_out}, {21'h0, jmp});
    @(posedge clock);
  endtask

  task automatic quiet(input logic rst, input logic [31:0] addr, input logic [31:0] data,
                       input logic rw, input logic mr, input logic mw);
    drive(rst, addr, data, 5'd3, 1'b0, rw, mr, mw, 1'b0, 1'b0, 11'h0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [W-1:0] exp, act;
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {read_data_out, result_out, reg_dest_out, MemToReg_out, RegWrite_out, mem_fault_out};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL memwb: got rd=%h res=%h dest=%0d m2r=%b rw=%b flt=%b expected rd=%h res=%h dest=%0d m2r=%b rw=%b flt=%b",
                 act[71:40], act[39:8], act[7:3], act[2], act[1], act[0],
                 exp[71:40], exp[39:8], exp[7:3], exp[2], exp[1], exp[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d;
    reset = 1'b1; result_in = '0; registro_2_in = '0; reg_dest_in = '0;
    jump_dest_addr_in = '0; zero_signal_in = 1'b0; MemToReg_in = 1'b0;
    RegWrite_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; Branch_in = 1'b0;

    // Reset with busy inputs: outputs must be zero.
    drive(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 11'h7FF);
    drive(1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0);
    #2 check_val("reset_read", read_data_out, 32'h0);

    // Fill every word so later loads are fully predictable.
    for (int i = 0; i < 256; i++) quiet(1'b0, i * 4, $urandom, 1'b0, 1'b0, 1'b1);

    // Store then load, read in the following cycle.
    quiet(1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0);
    #2 check_val("load_after_store", read_data_out, 32'hDEADBEEF);
    check_val("load_regwrite", {31'h0, RegWrite_out}, 32'h1);

    // Address wrap.
    quiet(1'b0, 32'h0000_0410, 32'hCAFE_0410, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0);
    #2 check_val("wrap_load", read_data_out, 32'hCAFE_0410);

    // Misaligned load and store.
    quiet(1'b0, 32'h20, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 32'h13, 32'h0, 1'b1, 1'b1, 1'b0);
    #2 check_val("mis_fault", {31'h0, mem_fault_out}, 32'h1);
    check_val("mis_read", read_data_out, 32'h0);
    check_val("mis_regwrite", {31'h0, RegWrite_out}, 32'h0);
    quiet(1'b0, 32'h21, 32'h1111_2222, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 1'b0);
    #2 check_val("mis_store_kept", read_data_out, 32'h0BAD_F00D);

    // Branch resolution.
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h2A);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h2A);

    // Reset during a store, with branch asserted.
    quiet(1'b0, 32'h4, 32'h7777_0004, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h4, 32'h55, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 11'h15);
    #2 check_val("rst_result", result_out, 32'h0);
    quiet(1'b0, 32'h4, 32'h0, 1'b1, 1'b1, 1'b0);
    #2 check_val("rst_mem_kept", read_data_out, 32'h7777_0004);

    // Simultaneous read and write: write-first.
    quiet(1'b0, 32'h8, 32'h1234, 1'b1, 1'b1, 1'b1);
    #2 check_val("rw_first", read_data_out, 32'h1234);
    quiet(1'b0, 32'h8, 32'h0, 1'b1, 1'b1, 1'b0);
    #2 check_val("rw_stored", read_data_out, 32'h1234);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(1) == 0) a[31:6] = '0;  // concentrate on few words
      d = $urandom;
      drive($urandom_range(19) == 0, a, d, 5'($urandom_range(31)),
            1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 11'($urandom_range(2047)));
    end

    @(negedge clock);
    @(negedge clock);
    check_val("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: DATA_DEPTH, 256, number of 32-bit words in data memory (power of two).
REQ-002 Parameter: ADDR_WIDTH, 8, log2(DATA_DEPTH) word-index bits.
REQ-003 Single clock and reset: clock, rising-edge active; reset is synchronous and active-high.
REQ-004 clock  in  1  stage clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 result_in  in  32  ALU result from EX/MEM; byte address for loads/stores.
REQ-007 registro_2_in  in  32  store data.
REQ-008 reg_dest_in  in  5  destination register.
REQ-009 jump_dest_addr_in  in  11  branch target.
REQ-010 zero_signal_in  in  1  ALU zero flag.
REQ-011 MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in  in  1 each  control from EX/MEM.
REQ-012 read_data_out  out  32  MEM/WB loaded word.
REQ-013 result_out  out  32  MEM/WB copy of result_in.
REQ-014 reg_dest_out  out  5  MEM/WB destination register.
REQ-015 MemToReg_out, RegWrite_out  out  1 each  MEM/WB control.
REQ-016 mem_fault_out  out  1  MEM/WB misaligned-access flag.
REQ-017 PCSrc_out  out  1  branch-taken to fetch stage.
REQ-018 branch_target_out  out  11  branch target to fetch stage.

Function
REQ-019 Word index SHALL be result_in[ADDR_WIDTH+1:2]; higher address bits ignored (wrap modulo DATA_DEPTH).
REQ-020 Access is aligned when result_in[1:0]==2'b00, else misaligned.
REQ-021 Aligned store: at the rising edge with MemWrite_in=1 and reset=0, mem[index] SHALL take registro_2_in.
REQ-022 Misaligned store SHALL NOT modify memory.
REQ-023 Load latency is 1 cycle: at the edge with MemRead_in=1, aligned, reset=0, read_data_out SHALL take mem[index].
REQ-024 When MemRead_in=0 or the load is misaligned, read_data_out SHALL load 32'h0 at that edge.
REQ-025 MemRead_in and MemWrite_in both 1, aligned: write performed; read_data_out SHALL load registro_2_in (write-first).
REQ-026 Load in the cycle after a store to the same index SHALL return the stored value.
REQ-027 Each edge (reset=0): result_out, reg_dest_out, MemToReg_out, RegWrite_out SHALL load their _in values.
REQ-028 mem_fault_out SHALL load 1 when (MemRead_in|MemWrite_in) and misaligned, else 0; RegWrite_out SHALL load 0 on a misaligned load.
REQ-029 PCSrc_out SHALL be combinational Branch_in & zero_signal_in, forced 0 while reset=1.
REQ-030 branch_target_out SHALL be combinational jump_dest_addr_in.

Reset
REQ-031 At an edge with reset=1, all registered outputs SHALL become 0, regardless of other inputs.
REQ-032 Memory contents SHALL be unaffected by reset; stores SHALL be suppressed while reset=1.
REQ-033 Reset asserted mid-stream discards the in-flight MEM/WB entry; first post-reset edge loads normally.

Structure
REQ-034 Shared package pipeline_pkg SHALL hold DATA_DEPTH/ADDR_WIDTH defaults, WORD_BYTES=4, and the MEM/WB control-bundle typedef.
REQ-035 The storage SHALL be a sub-module data_memory (single-port, synchronous write, write-first synchronous read); MEM/WB register stays in memory_access.

Verification
REQ-036 Store result_in=32'h10, registro_2_in=32'hDEADBEEF; next cycle load 32'h10 -> read_data_out=32'hDEADBEEF one cycle later, RegWrite_out follows input.
REQ-037 Store to 32'h0000_0410 (DATA_DEPTH=256) then load 32'h10 -> read returns stored value (wrap).
REQ-038 Load result_in=32'h13, RegWrite_in=1 -> mem_fault_out=1, read_data_out=0, RegWrite_out=0; misaligned store 32'h21 leaves mem[8] unchanged.
REQ-039 Branch_in=1, zero_signal_in=1, jump_dest_addr_in=11'h2A -> same-cycle PCSrc_out=1, branch_target_out=11'h2A; zero_signal_in=0 -> PCSrc_out=0.
REQ-040 Assert reset during store of 32'h55 to 32'h4 -> all outputs 0 next edge, mem[1] unchanged, PCSrc_out=0 while reset=1.
REQ-041 MemRead_in=MemWrite_in=1, addr 32'h8, data 32'h1234 -> read_data_out=32'h1234, mem[2]=32'h1234.
